trig_lookup_arbiter: RTL and testbench

//  Shares one dual-port cosine ROM (cos.mem) among NUM_REQ angle-lookup requesters.

---
 rtl/game_pkg.sv | 60 ++++++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv | 51 +++++
 rtl/trig_lookup_arbiter.sv | 105 ++++++++++
 tb/tb_trig_lookup_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game-side types and trig helpers: angle/trig types, quarter-wave cosine
// table and the angle folding used to address the shared trig ROM.
package game_pkg;

    localparam int unsigned ANGLE_W   = 9;
    localparam int unsigned TRIG_W    = 11;
    localparam int unsigned ANGLE_MAX = 360;
    localparam int unsigned TRIG_ONE  = 512;
    localparam int unsigned QUARTER   = 90;

    typedef logic [ANGLE_W-1:0]        angle_t;
    typedef logic signed [TRIG_W-1:0]  trig_t;

    // round(512*sin(k deg)) for k = 0..90; cosine is read back-to-front
    localparam logic [TRIG_W-2:0] SIN_Q [0:90] = '{
          0,   9,  18,  27,  36,  45,  54,  62,  71,  80,
         89,  98, 106, 115, 124, 133, 141, 150, 158, 167,
        175, 183, 192, 200, 208, 216, 224, 232, 240, 248,
        256, 264, 271, 279, 286, 294, 301, 308, 315, 322,
        329, 336, 343, 349, 356, 362, 368, 374, 380, 386,
        392, 398, 403, 409, 414, 419, 424, 429, 434, 439,
        443, 448, 452, 456, 460, 464, 468, 471, 475, 478,
        481, 484, 487, 490, 492, 495, 497, 499, 501, 503,
        504, 506, 507, 508, 509, 510, 511, 511, 512, 512,
        (TRIG_W-1)'(TRIG_ONE)
    };

    // Single subtract: 360..511 folds into 0..151
    function automatic angle_t norm_angle(input angle_t a);
        return (a >= ANGLE_W'(ANGLE_MAX)) ? a - ANGLE_W'(ANGLE_MAX) : a;
    endfunction

    // sin(a) = cos(a - 90), wrapped into 0..359
    function automatic angle_t sin_addr(input angle_t a);
        return (a >= ANGLE_W'(QUARTER)) ? a - ANGLE_W'(QUARTER)
                                        : a + ANGLE_W'(ANGLE_MAX - QUARTER);
    endfunction

    function automatic trig_t cos_deg(input angle_t d);
        logic [6:0] q;
        logic       neg;
        trig_t      mag;
        if (d <= ANGLE_W'(90)) begin
            q   = 7'(d);
            neg = 1'b0;
        end else if (d <= ANGLE_W'(180)) begin
            q   = 7'(ANGLE_W'(180) - d);
            neg = 1'b1;
        end else if (d <= ANGLE_W'(270)) begin
            q   = 7'(d - ANGLE_W'(180));
            neg = 1'b1;
        end else begin
            q   = 7'(ANGLE_W'(360) - d);
            neg = 1'b0;
        end
        mag = TRIG_W'(SIN_Q[7'(90) - q]);
        return neg ? -mag : mag;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after ptr, wrapping.
module rr_arbiter
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               vld_c
);

    logic [NUM_REQ-1:0] elig_c;

    assign elig_c = req & ~mask;

    // Upper segment [ptr..N-1] first, then the wrapped segment [0..ptr-1]
    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        vld_c = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!vld_c && elig_c[i] && (i >= int'(ptr))) begin
                vld_c    = 1'b1;
                gnt_c[i] = 1'b1;
                idx_c    = IDX_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!vld_c && elig_c[i] && (i < int'(ptr))) begin
                vld_c    = 1'b1;
                gnt_c[i] = 1'b1;
                idx_c    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Dual-port cosine ROM, one clock, LAT-deep read pipe; output register has
// its own clock enable and synchronous reset as in the vendor template.
module xilinx_true_dual_port_read_first_1_clock_ram
    import game_pkg::*;
#(
    parameter int unsigned LAT = 2
)
(
    input  logic   clka,
    input  logic   rsta,
    input  logic   rstb,
    input  logic   ena,
    input  logic   enb,
    input  logic   regcea,
    input  logic   regceb,
    input  angle_t addra,
    input  angle_t addrb,
    output trig_t  douta,
    output trig_t  doutb
);

    trig_t pipe_a_q [LAT];
    trig_t pipe_a_d [LAT];
    trig_t pipe_b_q [LAT];
    trig_t pipe_b_d [LAT];

    always_comb begin
        pipe_a_d = pipe_a_q;
        pipe_b_d = pipe_b_q;
        if (ena) pipe_a_d[0] = cos_deg(addra);
        if (enb) pipe_b_d[0] = cos_deg(addrb);
        for (int k = 1; k < int'(LAT); k++) begin
            pipe_a_d[k] = pipe_a_q[k-1];
            pipe_b_d[k] = pipe_b_q[k-1];
        end
        // Output stage: hold unless enabled, reset wins
        if (!regcea) pipe_a_d[LAT-1] = pipe_a_q[LAT-1];
        if (!regceb) pipe_b_d[LAT-1] = pipe_b_q[LAT-1];
        if (rsta)    pipe_a_d[LAT-1] = '0;
        if (rstb)    pipe_b_d[LAT-1] = '0;
    end

    always_ff @(posedge clka) begin
        pipe_a_q <= pipe_a_d;
        pipe_b_q <= pipe_b_d;
    end

    assign douta = pipe_a_q[LAT-1];
    assign doutb = pipe_b_q[LAT-1];

endmodule

// File: rtl/trig_lookup_arbiter.sv
// Shares one dual-port cosine ROM among NUM_REQ angle requesters; round-robin,
// one lookup per cycle, cos/sin returned ROM_LAT cycles after the grant, tagged by id.
module trig_lookup_arbiter
    import game_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned ROM_LAT = 2,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ANGLE_W-1:0] angle,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rsp_valid,
    output logic [IDX_W-1:0]           rsp_id,
    output trig_t                      rsp_cos,
    output trig_t                      rsp_sin
);

    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    angle_t             addr_a_q, addr_a_d;
    angle_t             addr_b_q, addr_b_d;
    logic [ROM_LAT:0]   tag_vld_q, tag_vld_d;
    logic [IDX_W-1:0]   tag_id_q [ROM_LAT+1];
    logic [IDX_W-1:0]   tag_id_d [ROM_LAT+1];

    logic [NUM_REQ-1:0] win_oh_c;
    logic [IDX_W-1:0]   win_idx_c;
    logic               win_vld_c;
    angle_t             ang_arr [NUM_REQ];
    angle_t             norm_a;

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
        assign ang_arr[g] = angle[g*ANGLE_W +: ANGLE_W];
    end

    // Last cycle's grant is the mask, so a held request cannot win back-to-back
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req),
        .mask  (gnt_q),
        .ptr   (ptr_q),
        .gnt_c (win_oh_c),
        .idx_c (win_idx_c),
        .vld_c (win_vld_c)
    );

    always_comb begin
        gnt_d     = win_oh_c;
        ptr_d     = ptr_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        norm_a    = norm_angle(ang_arr[win_idx_c]);
        tag_vld_d = {tag_vld_q[ROM_LAT-1:0], win_vld_c};
        tag_id_d[0] = win_idx_c;
        for (int k = 1; k <= int'(ROM_LAT); k++) begin
            tag_id_d[k] = tag_id_q[k-1];
        end
        if (win_vld_c) begin
            ptr_d    = (win_idx_c == IDX_W'(NUM_REQ-1)) ? '0 : win_idx_c + IDX_W'(1);
            addr_a_d = norm_a;
            addr_b_d = sin_addr(norm_a);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q     <= '0;
            ptr_q     <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '{default: '0};
        end else begin
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    // Output register only loads on a tagged lookup, so data holds between responses
    xilinx_true_dual_port_read_first_1_clock_ram #(.LAT(ROM_LAT)) u_rom (
        .clka   (clk),
        .rsta   (rst),
        .rstb   (rst),
        .ena    (tag_vld_q[0]),
        .enb    (tag_vld_q[0]),
        .regcea (tag_vld_q[ROM_LAT-1]),
        .regceb (tag_vld_q[ROM_LAT-1]),
        .addra  (addr_a_q),
        .addrb  (addr_b_q),
        .douta  (rsp_cos),
        .doutb  (rsp_sin)
    );

    assign gnt       = gnt_q;
    assign rsp_valid = tag_vld_q[ROM_LAT];
    assign rsp_id    = tag_id_q[ROM_LAT];

endmodule

// File: tb/tb_trig_lookup_arbiter.sv
// Bench for trig_lookup_arbiter: directed cases plus random requester traffic
// against a queue-based model using real-valued cos/sin with rounding.
module tb_trig_lookup_arbiter;
    import game_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ROM_LAT = 2;
    localparam real PI = 3.14159265358979;

    logic                       clk;
    logic                       rst;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*ANGLE_W-1:0] angle;
    logic [NUM_REQ-1:0]         gnt;
    logic                       rsp_valid;
    logic [1:0]                 rsp_id;
    trig_t                      rsp_cos;
    trig_t                      rsp_sin;
    int                         ang [NUM_REQ];

    typedef struct {
        int due;
        int id;
        int c;
        int s;
    } exp_t;

    exp_t q[$];
    int   n_tests, n_fail, cyc;
    int   m_ptr, m_last, last_cos, last_sin, last_win;

    trig_lookup_arbiter #(.NUM_REQ(NUM_REQ), .ROM_LAT(ROM_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .angle     (angle),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_cos   (rsp_cos),
        .rsp_sin   (rsp_sin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        angle = '0;
        for (int i = 0; i < NUM_REQ; i++) angle[i*ANGLE_W +: ANGLE_W] = ANGLE_W'(ang[i]);
    end

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic int exp_cos(input int a);
        int n;
        n = (a >= 360) ? a - 360 : a;
        return rnd(512.0 * $cos(real'(n) * PI / 180.0));
    endfunction

    function automatic int exp_sin(input int a);
        int n;
        n = (a >= 360) ? a - 360 : a;
        return rnd(512.0 * $sin(real'(n) * PI / 180.0));
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: predict grant from current inputs, advance, then check outputs
    task automatic tick();
        int   win;
        exp_t e;
        win = -1;
        if (rst) begin
            m_ptr = 0;
            m_last = -1;
            q.delete();
            last_cos = 0;
            last_sin = 0;
        end else begin
            for (int off = 0; off < NUM_REQ; off++) begin
                int i;
                i = (m_ptr + off) % NUM_REQ;
                if (win < 0 && req[i] && i != m_last) win = i;
            end
            if (win >= 0) begin
                e.due = cyc + 1 + ROM_LAT;
                e.id  = win;
                e.c   = exp_cos(ang[win]);
                e.s   = exp_sin(ang[win]);
                q.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("gnt", int'(gnt), (win >= 0) ? (1 << win) : 0);
        m_last = win;
        if (win >= 0) m_ptr = (win + 1) % NUM_REQ;
        last_win = win;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rsp_valid", int'(rsp_valid), 1);
            chk("rsp_id", int'(rsp_id), e.id);
            chk("rsp_cos", int'(rsp_cos), e.c);
            chk("rsp_sin", int'(rsp_sin), e.s);
            last_cos = e.c;
            last_sin = e.s;
        end else begin
            chk("rsp_idle", int'(rsp_valid), 0);
            chk("cos_hold", int'(rsp_cos), last_cos);
            chk("sin_hold", int'(rsp_sin), last_sin);
        end
    endtask

    // Requesters hold until granted; afterwards they may drop or start a new lookup
    task automatic rand_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && last_win == i) begin
                req[i] = 1'($urandom_range(0, 1));
                ang[i] = int'($urandom_range(0, 511));
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                req[i] = 1'b1;
                ang[i] = int'($urandom_range(0, 511));
            end
        end
    endtask

    task automatic one_shot(input int id, input int a);
        ang[id] = a;
        req[id] = 1'b1;
        tick();
        req[id] = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int t2_ang [4];
        int t2_cos [4];
        int t2_sin [4];
        int prev2;
        t2_ang = '{90, 180, 270, 359};
        t2_cos = '{0, -512, 0, 512};
        t2_sin = '{512, 0, -512, -9};
        n_tests = 0; n_fail = 0; cyc = 0;
        m_ptr = 0; m_last = -1; last_cos = 0; last_sin = 0; last_win = -1;
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < NUM_REQ; i++) ang[i] = 0;
        tick();
        tick();
        chk("rst_id", int'(rsp_id), 0);
        rst = 1'b0;

        // Single lookup at angle 0
        ang[0] = 0;
        req = 4'b0001;
        tick();
        chk("t1_gnt", int'(gnt), 1);
        req = 4'b0000;
        tick();
        tick();
        chk("t1_valid", int'(rsp_valid), 1);
        chk("t1_cos", int'(rsp_cos), 512);
        chk("t1_sin", int'(rsp_sin), 0);

        // Quadrant angles on requester 1
        for (int k = 0; k < 4; k++) begin
            one_shot(1, t2_ang[k]);
            chk("t2_cos", int'(rsp_cos), t2_cos[k]);
            chk("t2_sin", int'(rsp_sin), t2_sin[k]);
        end

        // All four held: strict rotation from index 0 after a reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) ang[i] = 17 + 83 * i;
        req = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("t3_order", int'(gnt), 1 << (k % 4));
            ang[k % 4] = ang[k % 4] + 5;
        end
        req = 4'b0000;
        repeat (3) tick();

        // Lone requester: grant every other cycle
        prev2 = 0;
        ang[2] = 123;
        req = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t4_no_b2b", int'(gnt[2]) & prev2, 0);
            prev2 = int'(gnt[2]);
        end
        req = 4'b0000;
        repeat (3) tick();

        // Out-of-range angles fold by one subtract
        one_shot(3, 450);
        chk("t5_450_cos", int'(rsp_cos), 0);
        chk("t5_450_sin", int'(rsp_sin), 512);
        one_shot(3, 360);
        chk("t5_360_cos", int'(rsp_cos), 512);
        chk("t5_360_sin", int'(rsp_sin), 0);

        // Reset with lookups in flight drops them
        for (int i = 0; i < NUM_REQ; i++) ang[i] = 30 + 40 * i;
        req = 4'b1111;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0000;
        repeat (3) tick();
        chk("t6_valid", int'(rsp_valid), 0);
        chk("t6_cos", int'(rsp_cos), 0);
        chk("t6_sin", int'(rsp_sin), 0);
        chk("t6_id", int'(rsp_id), 0);
        req = 4'b1111;
        tick();
        chk("t6_first_gnt", int'(gnt), 1);
        req = 4'b0000;
        repeat (3) tick();

        // Random traffic with occasional reset
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            tick();
            rand_reqs();
        end
        rst = 1'b0;
        req = 4'b0000;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
